// File: rtl/phasecalc_pkg.sv
// Shared constants for the multi-channel phase calculator: CORDIC arctangent table,
// pi constants (Q3.16) and the engine state encoding.
package phasecalc_pkg;

  localparam int ITER_W  = 5;
  localparam int LUT_LEN = 24;

  // atan(2^-i) * 2^16, rounded to nearest
  localparam longint ATAN_Q16 [0:LUT_LEN-1] = '{
    51472, 30386, 16055, 8150, 4091, 2047, 1024, 512,
    256,   128,   64,    32,   16,   8,    4,    2,
    1,     0,     0,     0,    0,    0,    0,    0
  };

  localparam longint PI_Q16      = 205887;
  localparam longint HALF_PI_Q16 = 102944;
  localparam longint TWO_PI_Q16  = 411775;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    PREROT,
    ITER,
    STORE,
    DONE
  } state_t;

  function automatic longint scale_q16(input longint v, input int frac);
    if (frac >= 16) return v <<< (frac - 16);
    return (v + (longint'(1) <<< (15 - frac))) >>> (16 - frac);
  endfunction

  function automatic longint atan_scaled(input int i, input int frac);
    if (i < 0 || i >= LUT_LEN) return 0;
    return scale_q16(ATAN_Q16[i], frac);
  endfunction

endpackage

// File: rtl/cordic_vec_step.sv
// One combinational CORDIC vectoring micro-rotation: drives y toward zero and
// accumulates the rotated angle into z.
module cordic_vec_step #(
  parameter int W  = 37,
  parameter int AW = 19,
  parameter int IW = 5
) (
  input  logic signed [W-1:0]  x,
  input  logic signed [W-1:0]  y,
  input  logic signed [AW-1:0] z,
  input  logic [IW-1:0]        i,
  input  logic signed [AW-1:0] lut,
  output logic signed [W-1:0]  x_next,
  output logic signed [W-1:0]  y_next,
  output logic signed [AW-1:0] z_next
);

  logic signed [W-1:0] xs;
  logic signed [W-1:0] ys;

  assign xs = x >>> i;
  assign ys = y >>> i;

  // y below the axis rotates counter-clockwise (d=+1), otherwise clockwise
  always_comb begin
    if (y[W-1]) begin
      x_next = x - ys;
      y_next = y + xs;
      z_next = z - lut;
    end else begin
      x_next = x + ys;
      y_next = y - xs;
      z_next = z + lut;
    end
  end

endmodule

// File: rtl/phasecalc_multi.sv
// NCH-channel atan2 using one time-shared iterative CORDIC engine in vectoring mode.
// Optional macro PHASECALC_DIFF_EN adds phase_diff = angle[k] - angle[0], wrapped to [-pi, pi).
module phasecalc_multi
  import phasecalc_pkg::*;
#(
  parameter int NCH   = 4,
  parameter int XW    = 13,
  parameter int AW    = 19,
  parameter int FRAC  = 16,
  parameter int NITER = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              data_rdy,
  input  logic [NCH*XW-1:0] x,
  input  logic [NCH*XW-1:0] y,
  output logic [NCH*AW-1:0] angle,
`ifdef PHASECALC_DIFF_EN
  output logic [NCH*AW-1:0] phase_diff,
`endif
  output logic              angle_valid,
  output logic              busy,
  output logic              overrun
);

  // Two integer guard bits absorb CORDIC gain; the fractional bits below keep
  // tiny vectors such as (-1,0) from stalling on truncated shifts.
  localparam int G  = FRAC + 6;
  localparam int W  = XW + 2 + G;
  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic signed [AW-1:0] HALF_PI_S = AW'(scale_q16(HALF_PI_Q16, FRAC));

  state_t               state;
  logic [CW-1:0]        ch;
  logic [ITER_W-1:0]    iter;
  logic [NCH*XW-1:0]    x_bank;
  logic [NCH*XW-1:0]    y_bank;
  logic [NCH*AW-1:0]    shadow;
  logic signed [W-1:0]  xr;
  logic signed [W-1:0]  yr;
  logic signed [AW-1:0] zr;
  logic                 zero_in;
  logic signed [W-1:0]  x_next;
  logic signed [W-1:0]  y_next;
  logic signed [AW-1:0] z_next;
  logic signed [AW-1:0] lut_val;
  logic [XW-1:0]        x_sel;
  logic [XW-1:0]        y_sel;

  assign x_sel   = x_bank[ch*XW +: XW];
  assign y_sel   = y_bank[ch*XW +: XW];
  assign lut_val = AW'(atan_scaled(int'(iter), FRAC));

  cordic_vec_step #(
    .W (W),
    .AW(AW),
    .IW(ITER_W)
  ) u_step (
    .x     (xr),
    .y     (yr),
    .z     (zr),
    .i     (iter),
    .lut   (lut_val),
    .x_next(x_next),
    .y_next(y_next),
    .z_next(z_next)
  );

`ifdef PHASECALC_DIFF_EN
  localparam logic signed [AW:0] PI_W     = (AW+1)'(scale_q16(PI_Q16, FRAC));
  localparam logic signed [AW:0] TWO_PI_W = (AW+1)'(scale_q16(TWO_PI_Q16, FRAC));

  logic [NCH*AW-1:0] diff_c;
  logic signed [AW:0] a0;
  logic signed [AW:0] ak;
  logic signed [AW:0] dk;

  always_comb begin
    diff_c = '0;
    a0     = {shadow[AW-1], shadow[AW-1:0]};
    ak     = '0;
    dk     = '0;
    for (int k = 0; k < NCH; k++) begin
      ak = {shadow[k*AW+AW-1], shadow[k*AW +: AW]};
      dk = ak - a0;
      if (dk >= PI_W)       dk = dk - TWO_PI_W;
      else if (dk < -PI_W)  dk = dk + TWO_PI_W;
      diff_c[k*AW +: AW] = dk[AW-1:0];
    end
  end
`endif

  always_ff @(posedge clock) begin
    if (!reset) begin
      state       <= IDLE;
      ch          <= '0;
      iter        <= '0;
      x_bank      <= '0;
      y_bank      <= '0;
      shadow      <= '0;
      xr          <= '0;
      yr          <= '0;
      zr          <= '0;
      zero_in     <= 1'b0;
      angle       <= '0;
      angle_valid <= 1'b0;
      busy        <= 1'b0;
      overrun     <= 1'b0;
`ifdef PHASECALC_DIFF_EN
      phase_diff  <= '0;
`endif
    end else begin
      angle_valid <= 1'b0;
      if (data_rdy && busy) overrun <= 1'b1;
      case (state)
        IDLE: begin
          if (data_rdy) begin
            x_bank <= x;
            y_bank <= y;
            busy   <= 1'b1;
            ch     <= '0;
            state  <= LOAD;
          end
        end
        LOAD: begin
          xr      <= {{2{x_sel[XW-1]}}, x_sel, {G{1'b0}}};
          yr      <= {{2{y_sel[XW-1]}}, y_sel, {G{1'b0}}};
          zr      <= '0;
          zero_in <= (x_sel == '0) && (y_sel == '0);
          state   <= PREROT;
        end
        // fold the left half-plane into the right so the iterations converge
        PREROT: begin
          if (xr[W-1]) begin
            if (!yr[W-1]) begin
              xr <= yr;
              yr <= -xr;
              zr <= HALF_PI_S;
            end else begin
              xr <= -yr;
              yr <= xr;
              zr <= -HALF_PI_S;
            end
          end
          iter  <= '0;
          state <= ITER;
        end
        ITER: begin
          xr   <= x_next;
          yr   <= y_next;
          zr   <= z_next;
          iter <= iter + 1'b1;
          if (iter == ITER_W'(NITER - 1)) state <= STORE;
        end
        STORE: begin
          shadow[ch*AW +: AW] <= zero_in ? '0 : zr;
          if (ch == CW'(NCH - 1)) begin
            state <= DONE;
          end else begin
            ch    <= ch + 1'b1;
            state <= LOAD;
          end
        end
        DONE: begin
          angle       <= shadow;
          angle_valid <= 1'b1;
          busy        <= 1'b0;
          state       <= IDLE;
`ifdef PHASECALC_DIFF_EN
          phase_diff  <= diff_c;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_phasecalc_multi.sv
// Scoreboard bench for phasecalc_multi: expectations come from real-valued atan2 and
// are queued at issue time; a negedge monitor pops and compares on angle_valid.
module tb_phasecalc_multi;

  localparam int  NCH   = 4;
  localparam int  XW    = 13;
  localparam int  AW    = 19;
  localparam int  FRAC  = 16;
  localparam int  NITER = 16;
  localparam int  LAT   = NCH * (NITER + 3) + 2;
  localparam int  TOL   = 4;
  localparam real SCALE = 65536.0;
  localparam real PI_R  = 3.14159265358979323846;

  logic              clock;
  logic              reset;
  logic              data_rdy;
  logic [NCH*XW-1:0] x;
  logic [NCH*XW-1:0] y;
  logic [NCH*AW-1:0] angle;
  logic              angle_valid;
  logic              busy;
  logic              overrun;
`ifdef PHASECALC_DIFF_EN
  logic [NCH*AW-1:0] phase_diff;
  int                exp_diff[$];
`endif

  int cycle;
  int n_compared;
  int n_mismatched;
  int exp_angle[$];
  int exp_issue[$];
  int fx[NCH];
  int fy[NCH];
  int last_issue;
  int t0;

  phasecalc_multi #(
    .NCH  (NCH),
    .XW   (XW),
    .AW   (AW),
    .FRAC (FRAC),
    .NITER(NITER)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .data_rdy   (data_rdy),
    .x          (x),
    .y          (y),
    .angle      (angle),
`ifdef PHASECALC_DIFF_EN
    .phase_diff (phase_diff),
`endif
    .angle_valid(angle_valid),
    .busy       (busy),
    .overrun    (overrun)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial cycle = 0;
  always @(posedge clock) cycle <= cycle + 1;

  function automatic real ideal_rad(input int xi, input int yi);
    if (xi == 0 && yi == 0) return 0.0;
    return $atan2(real'(yi), real'(xi));
  endfunction

  function automatic int to_lsb(input real r);
    return $rtoi($floor(r * SCALE + 0.5));
  endfunction

  function automatic int rand_full();
    return int'($urandom_range(8191)) - 4096;
  endfunction

  function automatic int rand_small();
    return int'($urandom_range(40)) - 20;
  endfunction

  task automatic check_output(input string name, input int act, input int req, input int tol);
    int err;
    err = act - req;
    n_compared++;
    if (err > tol || err < -tol) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d (tol %0d) at cycle %0d", name, act, req, tol, cycle);
    end
  endtask

  // Drive fx/fy for one cycle; when expect_out is set the reference result is queued.
  task automatic apply_stimulus(input bit expect_out);
    real r0;
    real rk;
    for (int k = 0; k < NCH; k++) begin
      x[k*XW +: XW] = XW'(fx[k]);
      y[k*XW +: XW] = XW'(fy[k]);
    end
    if (expect_out) begin
      r0 = ideal_rad(fx[0], fy[0]);
      for (int k = 0; k < NCH; k++) begin
        rk = ideal_rad(fx[k], fy[k]);
        exp_angle.push_back(to_lsb(rk));
`ifdef PHASECALC_DIFF_EN
        rk = rk - r0;
        while (rk >= PI_R) rk = rk - 2.0 * PI_R;
        while (rk < -PI_R) rk = rk + 2.0 * PI_R;
        exp_diff.push_back((k == 0) ? 0 : to_lsb(rk));
`endif
      end
      exp_issue.push_back(cycle);
      last_issue = cycle;
    end
    data_rdy = 1'b1;
    @(posedge clock);
    #1;
    data_rdy = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((exp_issue.size() != 0 || busy) && n < 400) begin
      @(posedge clock);
      #1;
      n++;
    end
    if (exp_issue.size() != 0 || busy) begin
      n_compared++;
      n_mismatched++;
      $display("[TB] FAIL timeout: %0d frames still pending, busy=%0b", exp_issue.size(), busy);
      exp_issue.delete();
      exp_angle.delete();
`ifdef PHASECALC_DIFF_EN
      exp_diff.delete();
`endif
    end
  endtask

  task automatic random_frame();
    for (int k = 0; k < NCH; k++) begin
      if ($urandom_range(3) == 0) begin
        fx[k] = rand_small();
        fy[k] = rand_small();
      end else begin
        fx[k] = rand_full();
        fy[k] = rand_full();
      end
    end
  endtask

  // Monitor: every angle_valid must match the oldest queued frame.
  always @(negedge clock) begin
    if (angle_valid === 1'b1) begin
      if (exp_issue.size() == 0) begin
        n_compared++;
        n_mismatched++;
        $display("[TB] FAIL spurious_valid: angle_valid=1 at cycle %0d, expected 0", cycle);
      end else begin
        check_output("latency", cycle - exp_issue.pop_front(), LAT, 0);
        for (int k = 0; k < NCH; k++) begin
          check_output($sformatf("angle_ch%0d", k), int'($signed(angle[k*AW +: AW])),
                       exp_angle.pop_front(), TOL);
        end
`ifdef PHASECALC_DIFF_EN
        for (int k = 0; k < NCH; k++) begin
          int act;
          int req;
          act = int'($signed(phase_diff[k*AW +: AW]));
          req = exp_diff.pop_front();
          if (act - req > 205887) act = act - 411775;
          else if (act - req < -205887) act = act + 411775;
          check_output($sformatf("phase_diff_ch%0d", k), act, req, (k == 0) ? 0 : 2 * TOL);
        end
`endif
      end
    end
  end

  initial begin
    n_compared   = 0;
    n_mismatched = 0;
    last_issue   = 0;
    reset        = 1'b0;
    data_rdy     = 1'b0;
    x            = '0;
    y            = '0;
    repeat (3) @(posedge clock);
    #1;
    for (int k = 0; k < NCH; k++)
      check_output($sformatf("reset_angle_ch%0d", k), int'($signed(angle[k*AW +: AW])), 0, 0);
    check_output("reset_angle_valid", int'(angle_valid), 0, 0);
    check_output("reset_busy", int'(busy), 0, 0);
    check_output("reset_overrun", int'(overrun), 0, 0);
    reset = 1'b1;
    @(posedge clock);
    #1;

    // cardinal directions
    fx = '{1000, 0, -1000, 1000};
    fy = '{0, 1000, 0, -1000};
    apply_stimulus(1'b1);
    wait_idle();

    // extremes, zero vector and the +pi case
    fx = '{-4096, 4095, 0, -1};
    fy = '{-4096, -4096, 0, 0};
    apply_stimulus(1'b1);
    wait_idle();
    check_output("overrun_clear", int'(overrun), 0, 0);

    // data_rdy while busy, then again during the DONE cycle
    random_frame();
    apply_stimulus(1'b1);
    t0 = last_issue;
    while (cycle < t0 + 10) begin @(posedge clock); #1; end
    random_frame();
    apply_stimulus(1'b0);
    check_output("overrun_set", int'(overrun), 1, 0);
    while (cycle < t0 + LAT - 1) begin @(posedge clock); #1; end
    check_output("busy_in_done", int'(busy), 1, 0);
    random_frame();
    apply_stimulus(1'b0);
    check_output("valid_after_done", int'(angle_valid), 1, 0);
    wait_idle();
    repeat (LAT + 20) @(posedge clock);
    #1;
    check_output("overrun_sticky", int'(overrun), 1, 0);
    check_output("busy_after_drop", int'(busy), 0, 0);

    // reset mid-frame aborts it
    random_frame();
    apply_stimulus(1'b1);
    t0 = last_issue;
    while (cycle < t0 + 30) begin @(posedge clock); #1; end
    reset = 1'b0;
    exp_issue.delete();
    exp_angle.delete();
`ifdef PHASECALC_DIFF_EN
    exp_diff.delete();
`endif
    @(posedge clock);
    #1;
    for (int k = 0; k < NCH; k++)
      check_output($sformatf("abort_angle_ch%0d", k), int'($signed(angle[k*AW +: AW])), 0, 0);
    check_output("abort_busy", int'(busy), 0, 0);
    check_output("abort_overrun", int'(overrun), 0, 0);
    reset = 1'b1;
    repeat (LAT + 10) @(posedge clock);
    #1;

    // randomized frames, issued as soon as the previous one completes
    for (int f = 0; f < 240; f++) begin
      random_frame();
      apply_stimulus(1'b1);
      wait_idle();
    end
    check_output("overrun_final", int'(overrun), 0, 0);

    repeat (20) @(posedge clock);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
